td4_prog_rom: RTL and testbench



---
 rtl/td4_prog_rom.sv | 151 +++++++++++++++
 tb/tb_td4_prog_rom.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/td4_prog_rom.sv
// td4_prog_rom: 16 x 8-bit flop-based program memory for the TD4 CPU.
// The CPU reads data = mem[addres] combinationally. A slow two-wire serial
// loader (ld_sclk/ld_sdi, MSB first) can rewrite all 16 words; the CPU is
// held in reset (cpu_rst_n low) for as long as the block is out of RUN.
// Ports:
//   clk, rst        system clock, synchronous active-high reset
//   addres, data    CPU fetch address and instruction word {op, im}
//   ld_en           level request/hold for load mode
//   ld_sclk, ld_sdi asynchronous serial loader clock and data
//   ld_busy         high while loading
//   ld_done         high once all 16 words are loaded, until ld_en falls
//   cpu_rst_n       active-low CPU reset, low whenever not in RUN
module td4_prog_rom #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  RESET_WORD  = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] addres,
  output logic [7:0] data,
  input  logic       ld_en,
  input  logic       ld_sclk,
  input  logic       ld_sdi,
  output logic       ld_busy,
  output logic       ld_done,
  output logic       cpu_rst_n
);

  localparam int unsigned WORDS  = 16;
  localparam int unsigned WORD_W = 8;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_LOAD = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WORD_W-1:0]        mem_q [WORDS];
  logic [WORD_W-1:0]        mem_d [WORDS];
  logic [2:0]               bcnt_q, bcnt_d;
  logic [3:0]               wptr_q, wptr_d;
  logic [6:0]               sh_q, sh_d;
  logic [SYNC_STAGES-1:0]   sclk_sync_q, sclk_sync_d;
  logic [SYNC_STAGES-1:0]   sdi_sync_q, sdi_sync_d;
  logic                     sclk_q, sclk_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic                     cpu_rst_n_q, cpu_rst_n_d;

  logic                     sclk_s;
  logic                     sdi_s;
  logic                     sclk_rise;

  // Synchronised loader signals; the edge is judged against one extra copy
  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_q;

  // Combinational read, no latency
  assign data      = mem_q[addres];
  assign ld_busy   = busy_q;
  assign ld_done   = done_q;
  assign cpu_rst_n = cpu_rst_n_q;

  // Next-state, loader datapath and output decode
  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    bcnt_d      = bcnt_q;
    wptr_d      = wptr_q;
    sh_d        = sh_q;
    sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], ld_sclk};
    sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0], ld_sdi};
    sclk_d      = sclk_s;

    case (state_q)
      S_RUN: begin
        if (ld_en) begin
          state_d = S_LOAD;
          bcnt_d  = 3'd0;
          wptr_d  = 4'd0;
          sh_d    = 7'd0;
        end
      end
      S_LOAD: begin
        // Abort takes priority over a coincident edge; partial byte dropped
        if (!ld_en) begin
          state_d = S_RUN;
        end else if (sclk_rise) begin
          if (bcnt_q != 3'd7) begin
            sh_d   = {sh_q[5:0], sdi_s};
            bcnt_d = bcnt_q + 3'd1;
          end else begin
            mem_d[wptr_q] = {sh_q, sdi_s};
            bcnt_d        = 3'd0;
            wptr_d        = wptr_q + 4'd1;
            if (wptr_q == 4'd15) begin
              state_d = S_DONE;
            end
          end
        end
      end
      S_DONE: begin
        if (!ld_en) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    // Outputs follow the state on the same edge
    busy_d      = (state_d == S_LOAD);
    done_d      = (state_d == S_DONE);
    cpu_rst_n_d = (state_d == S_RUN);
  end

  // State, storage and synchroniser registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      for (int i = 0; i < WORDS; i++) begin
        mem_q[i] <= RESET_WORD;
      end
      bcnt_q      <= 3'd0;
      wptr_q      <= 4'd0;
      sh_q        <= 7'd0;
      sclk_sync_q <= '0;
      sdi_sync_q  <= '0;
      sclk_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cpu_rst_n_q <= 1'b1;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      bcnt_q      <= bcnt_d;
      wptr_q      <= wptr_d;
      sh_q        <= sh_d;
      sclk_sync_q <= sclk_sync_d;
      sdi_sync_q  <= sdi_sync_d;
      sclk_q      <= sclk_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cpu_rst_n_q <= cpu_rst_n_d;
    end
  end

endmodule

// File: tb/tb_td4_prog_rom.sv
// tb_td4_prog_rom: randomized self-checking bench for td4_prog_rom.
// Expected memory contents come from a word-level model (exp_mem) that is
// updated whenever the bench completes a serial byte inside a load.
module tb_td4_prog_rom;

  logic       clk;
  logic       rst;
  logic [3:0] addres;
  logic [7:0] data;
  logic       ld_en;
  logic       ld_sclk;
  logic       ld_sdi;
  logic       ld_busy;
  logic       ld_done;
  logic       cpu_rst_n;

  int unsigned n_checks;
  int unsigned n_fail;
  logic [7:0]  exp_mem [16];
  logic [7:0]  bytes   [16];

  td4_prog_rom dut (
    .clk       (clk),
    .rst       (rst),
    .addres    (addres),
    .data      (data),
    .ld_en     (ld_en),
    .ld_sclk   (ld_sclk),
    .ld_sdi    (ld_sdi),
    .ld_busy   (ld_busy),
    .ld_done   (ld_done),
    .cpu_rst_n (cpu_rst_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Advance n clocks and land just after the edge
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) exp_mem[i] = 8'hF0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick(2);
    rst = 1'b0;
    model_reset();
    tick(1);
  endtask

  task automatic check_status(input string tag, input logic busy, input logic done, input logic crn);
    check_eq({tag, "_busy"}, 32'(ld_busy), 32'(busy));
    check_eq({tag, "_done"}, 32'(ld_done), 32'(done));
    check_eq({tag, "_cpu_rst_n"}, 32'(cpu_rst_n), 32'(crn));
  endtask

  task automatic sweep(input string tag);
    for (int a = 0; a < 16; a++) begin
      addres = 4'(a);
      #1;
      check_eq($sformatf("%s_a%0d", tag, a), 32'(data), 32'(exp_mem[a]));
    end
  endtask

  // One serial bit: data set up well ahead of a slow sclk pulse (10 clk period)
  task automatic send_bit(input logic b);
    ld_sdi = b;
    tick(2);
    ld_sclk = 1'b1;
    tick(4);
    ld_sclk = 1'b0;
    tick(4);
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
  endtask

  task automatic start_load();
    ld_en = 1'b1;
    tick(1);
  endtask

  task automatic load_all(input string tag);
    for (int k = 0; k < 16; k++) begin
      send_byte(bytes[k]);
      exp_mem[k] = bytes[k];
      addres = 4'(k);
      #1;
      check_eq($sformatf("%s_wr%0d", tag, k), 32'(data), 32'(bytes[k]));
      check_eq($sformatf("%s_done%0d", tag, k), 32'(ld_done), 32'(k == 15));
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst      = 1'b0;
    addres   = 4'd0;
    ld_en    = 1'b0;
    ld_sclk  = 1'b0;
    ld_sdi   = 1'b0;
    model_reset();

    // Reset state
    do_reset();
    check_status("rst", 1'b0, 1'b0, 1'b1);
    sweep("rst");

    // Full load of 0x30+i
    start_load();
    check_status("enter", 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 16; i++) bytes[i] = 8'h30 + 8'(i);
    load_all("ld30");
    check_status("ld30_end", 1'b0, 1'b1, 1'b0);
    ld_en = 1'b0;
    tick(1);
    check_status("ld30_rel", 1'b0, 1'b0, 1'b1);
    sweep("ld30");

    // Full load of random words
    start_load();
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom_range(0, 255));
    load_all("ldrnd");
    ld_en = 1'b0;
    tick(1);
    check_status("ldrnd_rel", 1'b0, 1'b0, 1'b1);
    sweep("ldrnd");

    // Abort after 3 words plus 5 bits
    do_reset();
    start_load();
    send_byte(8'hA1); exp_mem[0] = 8'hA1;
    send_byte(8'hB2); exp_mem[1] = 8'hB2;
    send_byte(8'hC3); exp_mem[2] = 8'hC3;
    for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
    ld_en = 1'b0;
    tick(1);
    check_status("abort", 1'b0, 1'b0, 1'b1);
    sweep("abort");

    // Abort coinciding with the 8th bit edge: abort wins, no write
    do_reset();
    start_load();
    send_byte(8'h11); exp_mem[0] = 8'h11;
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    ld_sdi = 1'b1;
    tick(2);
    ld_sclk = 1'b1;
    tick(2);
    ld_en = 1'b0;
    tick(1);
    check_status("abort_edge", 1'b0, 1'b0, 1'b1);
    ld_sclk = 1'b0;
    tick(6);
    sweep("abort_edge");

    // Reset in the middle of a load
    start_load();
    send_byte(8'($urandom_range(0, 255)));
    send_byte(8'($urandom_range(0, 255)));
    ld_en = 1'b0;
    do_reset();
    check_status("midrst", 1'b0, 1'b0, 1'b1);
    sweep("midrst");

    // Edges in RUN are ignored
    for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)));
    check_status("run_edges", 1'b0, 1'b0, 1'b1);
    sweep("run_edges");

    // Edges in DONE are ignored, ld_done held while ld_en stays high
    start_load();
    for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom_range(0, 255));
    load_all("ld2");
    for (int i = 0; i < 10; i++) begin
      send_bit(1'($urandom_range(0, 1)));
      check_eq($sformatf("done_hold%0d", i), 32'(ld_done), 32'd1);
    end
    sweep("done_edges");
    ld_en = 1'b0;
    tick(1);
    check_status("done_rel", 1'b0, 1'b0, 1'b1);

    // sclk already high on LOAD entry must not count as an edge
    do_reset();
    ld_sclk = 1'b1;
    ld_sdi  = 1'b1;
    tick(6);
    start_load();
    tick(6);
    ld_sclk = 1'b0;
    tick(4);
    send_byte(8'h5A);
    exp_mem[0] = 8'h5A;
    check_status("prehigh", 1'b1, 1'b0, 1'b0);
    sweep("prehigh");
    ld_en = 1'b0;
    tick(1);
    check_status("prehigh_rel", 1'b0, 1'b0, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
